cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 19 +
 rtl/cache_fill_fsm_fill_counter.sv | 33 +++
 rtl/cache_fill_fsm.sv | 145 ++++++++++++++
 tb/tb_cache_fill_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and defaults for the cache block fill controller.
package cache_fill_fsm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  localparam int unsigned BLOCK_WORDS_DEF = 8;
  localparam int unsigned MEM_LATENCY_DEF = 4;
  localparam int unsigned CNT_W           = 4;
  localparam logic [15:0] BASE_MASK       = 16'hFFF0;

  // The word offset is OR-ed into the block-aligned base, so it can never carry into bit 4.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] word);
    return base | {12'h000, word, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill: clears synchronously, counts on enable, saturates at MAX.
module fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int unsigned MAX = BLOCK_WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX);

  logic [CNT_W-1:0] r_cnt;

  // Count register; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_en && (r_cnt < LP_MAX)) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues one read per block word, writes returned words
// into the data array and writes the tag alongside the final word.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic [15:0] memory_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        write_data_array,
  output logic [2:0]  word_index,
  output logic [15:0] fill_data,
  output logic        write_tag_array
);

  localparam logic [CNT_W-1:0] LP_WORDS = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(BLOCK_WORDS - 1);

  // word_index is 3 bits wide and response timing is count-driven, so these bounds are hard.
  if (BLOCK_WORDS < 1 || BLOCK_WORDS > 8 || MEM_LATENCY < 1) begin : g_bad_params
    $error("cache_fill_fsm: unsupported BLOCK_WORDS or MEM_LATENCY");
  end

  fill_state_e      r_state;
  fill_state_e      w_next_state;
  logic [15:0]      r_base;
  logic [CNT_W-1:0] w_req_cnt;
  logic [CNT_W-1:0] w_recv_cnt;
  logic             w_in_idle;
  logic             w_req_active;
  logic             w_wr;
  logic             w_last_word;

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_req_active = (r_state == ST_FILL) && (w_req_cnt < LP_WORDS);
  assign w_wr         = (r_state == ST_FILL) && memory_data_valid && (w_recv_cnt < LP_WORDS);
  assign w_last_word  = (w_recv_cnt == LP_LAST);

  // Counters sit at zero throughout IDLE, so every fill starts from word 0.
  fill_counter #(.MAX(BLOCK_WORDS)) u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_in_idle),
    .i_en  (w_req_active),
    .o_cnt (w_req_cnt)
  );

  fill_counter #(.MAX(BLOCK_WORDS)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_in_idle),
    .i_en  (w_wr),
    .o_cnt (w_recv_cnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Block base address, captured when a miss is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= 16'h0000;
    end else if (w_in_idle && miss_detected) begin
      r_base <= miss_address & BASE_MASK;
    end else begin
      r_base <= r_base;
    end
  end

  // Next-state logic; a fill ends on the edge that retires the last word.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (miss_detected) begin
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_wr && w_last_word) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode; array writes follow the returned data in the same cycle.
  always_comb begin
    mem_en           = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    word_index       = 3'd0;
    write_tag_array  = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_req_active) begin
          mem_en         = 1'b1;
          memory_address = word_addr(r_base, w_req_cnt[2:0]);
        end else begin
          mem_en         = 1'b0;
          memory_address = 16'h0000;
        end
        if (w_wr) begin
          write_data_array = 1'b1;
          word_index       = w_recv_cnt[2:0];
          write_tag_array  = w_last_word;
        end else begin
          write_data_array = 1'b0;
          word_index       = 3'd0;
          write_tag_array  = 1'b0;
        end
      end
      default: begin
        mem_en           = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        word_index       = 3'd0;
        write_tag_array  = 1'b0;
      end
    endcase
  end

  assign fsm_busy  = (r_state == ST_FILL);
  assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency memory model and a per-cycle expectation model.
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic [15:0] fill_data;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;

  req_t        q[$];
  int          cyc;
  int          n_cmp;
  int          n_bad;
  bit          m_fill;
  int          m_req;
  int          m_recv;
  logic [15:0] m_base;
  bit          gapped;
  bit          stray;
  logic [4:0]  gap_pat;
  int          busy_cycles;
  int          tag_cnt;
  int          wr_cnt;
  int          tag_cyc;
  int          start_cyc;
  logic [15:0] max_addr;
  logic [15:0] first_addr;
  bit          seen_req;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [22:0] obs_vec();
    return {fsm_busy, mem_en, memory_address, write_data_array, word_index, write_tag_array};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    busy_cycles = 0;
    tag_cnt     = 0;
    wr_cnt      = 0;
    tag_cyc     = -1;
    max_addr    = 16'h0000;
    first_addr  = 16'h0000;
    seen_req    = 1'b0;
  endtask

  // One clock cycle: drive memory response, check outputs at negedge, advance the model at posedge.
  task automatic run_cycle();
    bit          ee;
    bit          ew;
    logic [15:0] ea;
    logic [2:0]  ei;
    if (rst) begin
      m_fill = 1'b0; m_req = 0; m_recv = 0; m_base = 16'h0000;
    end
    if (q.size() > 0 && q[0].due <= cyc && (!gapped || gap_pat[cyc % 5])) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_word(q[0].addr);
      void'(q.pop_front());
    end else if (stray) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hBAD0;
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
    end
    ee = m_fill && (m_req < 8);
    ea = ee ? (m_base | 16'(m_req * 2)) : 16'h0000;
    ew = m_fill && memory_data_valid && (m_recv < 8);
    ei = ew ? 3'(m_recv) : 3'd0;
    @(negedge clk);
    chk($sformatf("outs_cyc%0d", cyc), 32'(obs_vec()),
        32'({m_fill, ee, ea, ew, ei, (ew && m_recv == 7)}));
    if (ew) chk($sformatf("data_cyc%0d", cyc), 32'(fill_data), 32'(mem_word(m_base | 16'(m_recv * 2))));
    if (fsm_busy) busy_cycles++;
    if (write_data_array) wr_cnt++;
    if (write_tag_array) begin tag_cnt++; tag_cyc = cyc; end
    if (mem_en) begin
      if (!seen_req) begin first_addr = memory_address; seen_req = 1'b1; end
      if (memory_address > max_addr) max_addr = memory_address;
      q.push_back('{memory_address, cyc + LAT});
    end
    @(posedge clk);
    if (rst) begin
      m_fill = 1'b0; m_req = 0; m_recv = 0; m_base = 16'h0000;
    end else if (!m_fill) begin
      if (miss_detected) begin
        m_fill = 1'b1; m_base = miss_address & 16'hFFF0; m_req = 0; m_recv = 0;
      end
    end else begin
      if (ee) m_req++;
      if (ew) begin
        if (m_recv == 7) m_fill = 1'b0;
        m_recv++;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic do_fill(input logic [15:0] addr, input int ncyc);
    miss_address  = addr;
    miss_detected = 1'b1;
    run_cycle();
    miss_detected = 1'b0;
    clr_stats();
    start_cyc = cyc;
    repeat (ncyc) run_cycle();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_fill = 1'b0; m_req = 0; m_recv = 0; m_base = 16'h0000;
    gapped = 1'b0; stray = 1'b0; gap_pat = 5'b01101;
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0000;
    memory_data_valid = 1'b0; memory_data = 16'h0000;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(obs_vec()), 32'h0);
    rst = 1'b0;
    repeat (2) run_cycle();

    // Basic fill
    do_fill(16'h1234, 14);
    chk("basic_busy_cycles", busy_cycles, 12);
    chk("basic_writes", wr_cnt, 8);
    chk("basic_tags", tag_cnt, 1);
    chk("basic_tag_offset", tag_cyc - start_cyc, 11);
    chk("basic_first_addr", 32'(first_addr), 32'h1230);
    chk("basic_max_addr", 32'(max_addr), 32'h123E);

    // Top-of-memory block
    do_fill(16'hFFFF, 14);
    chk("wrap_first_addr", 32'(first_addr), 32'hFFF0);
    chk("wrap_max_addr", 32'(max_addr), 32'hFFFE);
    chk("wrap_writes", wr_cnt, 8);

    // Back-to-back misses with miss held high; address change mid-fill must be ignored
    miss_address  = 16'h0400;
    miss_detected = 1'b1;
    run_cycle();
    clr_stats();
    start_cyc = cyc;
    repeat (3) run_cycle();
    miss_address = 16'h0812;
    repeat (10) run_cycle();
    miss_detected = 1'b0;
    repeat (14) run_cycle();
    chk("b2b_busy_cycles", busy_cycles, 24);
    chk("b2b_writes", wr_cnt, 16);
    chk("b2b_tags", tag_cnt, 2);
    chk("b2b_second_tag_offset", tag_cyc - start_cyc, 24);
    chk("b2b_max_addr", 32'(max_addr), 32'h081E);

    // Stray valids in IDLE, including right after a fill completes
    do_fill(16'h2000, 12);
    stray = 1'b1;
    clr_stats();
    repeat (4) run_cycle();
    stray = 1'b0;
    chk("stray_writes", wr_cnt, 0);
    chk("stray_tags", tag_cnt, 0);
    repeat (2) run_cycle();

    // Reset after word 3 is written
    do_fill(16'h3456, 8);
    chk("pre_reset_writes", wr_cnt, 4);
    rst = 1'b1;
    #1;
    chk("async_reset_outs", 32'(obs_vec()), 32'h0);
    clr_stats();
    repeat (2) run_cycle();
    rst = 1'b0;
    repeat (6) run_cycle();
    chk("post_reset_writes", wr_cnt, 0);
    chk("post_reset_tags", tag_cnt, 0);
    do_fill(16'h5678, 14);
    chk("refill_writes", wr_cnt, 8);
    chk("refill_tags", tag_cnt, 1);
    chk("refill_first_addr", 32'(first_addr), 32'h5670);

    // Gapped memory returns
    gapped = 1'b1;
    do_fill(16'hABCD, 26);
    gapped = 1'b0;
    chk("gap_writes", wr_cnt, 8);
    chk("gap_tags", tag_cnt, 1);
    chk("gap_queue_drained", q.size(), 0);
    chk("gap_idle_at_end", 32'(fsm_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
